// File: rtl/fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader_if
// Bundles the two buses seen by the fifo stream reader: the fifo read side
// (pop strobe, empty flag, head word) and the outgoing valid/ready stream.
//
// Signals:
//   fifo_empty      fifo empty flag                    (fifo   -> reader)
//   fifo_read_data  fifo head word, DATA_WIDTH bits    (fifo   -> reader)
//   fifo_read       pop strobe, one cycle per word     (reader -> fifo)
//   out_valid       out_data holds a valid word        (reader -> consumer)
//   out_data        stream word, DATA_WIDTH bits       (reader -> consumer)
//   out_ready       consumer accepts the word          (consumer -> reader)
//
// Modports:
//   master  the reader itself
//   slave   the environment (fifo plus downstream consumer)
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  fifo_read;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        input  out_ready,
        output fifo_read,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_read_data,
        output out_ready,
        input  fifo_read,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Read-side companion of the block-RAM fifo. Pops words through the fifo
// read/empty interface and presents them as a valid/ready stream. A small
// IDLE/SETTLE/READY state machine hides the RAM read latency and the
// write-to-empty settle time; a 2-entry skid buffer absorbs back-pressure.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   bus          fifo_stream_reader_if.master (fifo read side + stream side)
//   enable       1 = pops allowed; 0 = no new pops, buffered words drain
//   busy         1 while the skid buffer holds words or the FSM is not IDLE
//   count_clear  (FIFO_READER_COUNT_EN only) forces word_count to 0
//   word_count   (FIFO_READER_COUNT_EN only) transfers seen, wraps
//
// Configuration macro: FIFO_READER_COUNT_EN adds the transfer counter and
// the COUNT_WIDTH parameter. Without it the counter and its ports are absent.
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 8
`ifdef FIFO_READER_COUNT_EN
    ,
    parameter int COUNT_WIDTH = 32
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    fifo_stream_reader_if.master    bus,
    input  logic                    enable,
    output logic                    busy
`ifdef FIFO_READER_COUNT_EN
    ,
    input  logic                    count_clear,
    output logic [COUNT_WIDTH-1:0]  word_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        READY  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
    logic [DATA_WIDTH-1:0] skid1_q, skid1_d;

    logic valid;
    logic transfer;
    logic room;
    logic pop;

    assign valid    = (occ_q != 2'd0);
    assign transfer = valid & bus.out_ready;
    // A full buffer still has room when its head leaves in the same cycle.
    assign room     = (occ_q != 2'd2) | transfer;
    // Gated with reset_n so no word is pulled out of the fifo and then
    // thrown away by a reset landing on the same edge.
    assign pop      = reset_n & (state_q == READY) & ~bus.fifo_empty & enable & room;

    assign bus.fifo_read = pop;
    assign bus.out_valid = valid;
    assign bus.out_data  = skid0_q;
    assign busy          = valid | (state_q != IDLE);

    // Next-state logic for the pop sequencer and the skid buffer. Entry 0 is
    // always the oldest word; a transfer shifts entry 1 down, a pop fills the
    // first free slot (or the tail slot vacated by a simultaneous transfer).
    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        skid0_d = skid0_q;
        skid1_d = skid1_q;

        unique case (state_q)
            IDLE:    if (!bus.fifo_empty) state_d = SETTLE;
            SETTLE:  state_d = bus.fifo_empty ? IDLE : READY;
            READY: begin
                if (bus.fifo_empty) begin
                    state_d = IDLE;
                end else if (pop) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop && transfer) begin
            if (occ_q == 2'd2) begin
                skid0_d = skid1_q;
                skid1_d = bus.fifo_read_data;
            end else begin
                skid0_d = bus.fifo_read_data;
            end
        end else if (pop) begin
            if (occ_q == 2'd0) begin
                skid0_d = bus.fifo_read_data;
            end else begin
                skid1_d = bus.fifo_read_data;
            end
            occ_d = occ_q + 2'd1;
        end else if (transfer) begin
            skid0_d = skid1_q;
            occ_d   = occ_q - 2'd1;
        end
    end

    // State register for the sequencer and the skid buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            occ_q   <= 2'd0;
            skid0_q <= '0;
            skid1_q <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            skid0_q <= skid0_d;
            skid1_q <= skid1_d;
        end
    end

`ifdef FIFO_READER_COUNT_EN
    logic [COUNT_WIDTH-1:0] word_count_q;

    // Transfer counter; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n || count_clear) begin
            word_count_q <= '0;
        end else if (transfer) begin
            word_count_q <= word_count_q + COUNT_WIDTH'(1);
        end
    end

    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
// Directed bench for fifo_stream_reader. A queue stands in for the fifo:
// fifo_empty and the head word are driven from it each cycle and a sampled
// fifo_read pops it. Popped words go into a second queue that is the
// expected stream order; every transfer is compared against its front.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic busy;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_READER_COUNT_EN
    logic       count_clear;
    logic [7:0] word_count;
`endif

    fifo_stream_reader #(
        .DATA_WIDTH(DW)
`ifdef FIFO_READER_COUNT_EN
        ,
        .COUNT_WIDTH(8)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .enable(enable),
        .busy(busy)
`ifdef FIFO_READER_COUNT_EN
        ,
        .count_clear(count_clear),
        .word_count(word_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] poppedQ[$];

    logic          sRead;
    logic          sValid;
    logic [DW-1:0] sData;
    logic          sBusy;
    logic          prevRead = 1'b0;

    int cycle         = 0;
    int transfers     = 0;
    int consecReads   = 0;
    int badEmptyReads = 0;
    int orphanXfers   = 0;

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs and the fifo model at the falling edge,
    // sample the DUT shortly after, then update the fifo and scoreboard.
    task automatic applyStimulus(input logic rstn, input logic en, input logic rdy);
        logic [DW-1:0] expWord;
        @(negedge clk);
        reset_n            = rstn;
        enable             = en;
        bus.out_ready      = rdy;
        bus.fifo_empty     = (fifoQ.size() == 0);
        bus.fifo_read_data = (fifoQ.size() != 0) ? fifoQ[0] : '0;
        #1;
        sRead  = bus.fifo_read;
        sValid = bus.out_valid;
        sData  = bus.out_data;
        sBusy  = busy;
        cycle++;
        if (sRead && prevRead) consecReads++;
        if (sRead && bus.fifo_empty) badEmptyReads++;
        if (sRead && fifoQ.size() != 0) poppedQ.push_back(fifoQ.pop_front());
        if (sValid && rdy && rstn) begin
            transfers++;
            if (poppedQ.size() == 0) begin
                orphanXfers++;
            end else begin
                expWord = poppedQ.pop_front();
                checkOutput("stream_word", 32'(sData), 32'(expWord));
            end
        end
        if (!rstn) poppedQ.delete();
        prevRead = sRead;
    endtask

    initial begin
        int firstRead;
        int firstValid;
        int t0;
        int reads;
        int holdBad;
        int spacingBad;
        int lastRead;

        reset_n            = 1'b0;
        enable             = 1'b1;
        bus.out_ready      = 1'b1;
        bus.fifo_empty     = 1'b1;
        bus.fifo_read_data = '0;
`ifdef FIFO_READER_COUNT_EN
        count_clear        = 1'b0;
`endif

        // Reset state.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rst_valid", 32'(sValid), 0);
        checkOutput("rst_read", 32'(sRead), 0);
        checkOutput("rst_busy", 32'(sBusy), 0);
        checkOutput("rst_data", 32'(sData), 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("idle_busy", 32'(sBusy), 0);

        // Single word: read two cycles after empty falls, valid one later.
        fifoQ.push_back(8'hA5);
        firstRead  = -1;
        firstValid = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (sRead && firstRead < 0) firstRead = i;
            if (sValid && firstValid < 0) begin
                firstValid = i;
                checkOutput("single_data", 32'(sData), 32'h0000_00A5);
            end
        end
        checkOutput("single_read_lat", 32'(firstRead), 2);
        checkOutput("single_valid_lat", 32'(firstValid), 3);
        checkOutput("single_after_busy", 32'(sBusy), 0);

        // Eight preloaded words, consumer always ready: one pop every 2 cycles.
        for (int i = 0; i < 8; i++) fifoQ.push_back(8'(i));
        t0         = transfers;
        spacingBad = 0;
        lastRead   = -1;
        for (int i = 0; i < 60 && (transfers - t0) < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (sRead) begin
                if (lastRead >= 0 && (cycle - lastRead) != 2) spacingBad++;
                lastRead = cycle;
            end
        end
        checkOutput("burst_count", 32'(transfers - t0), 8);
        checkOutput("burst_spacing", 32'(spacingBad), 0);

        // Back-pressure: four queued, consumer stalled -> exactly two pops.
        for (int i = 0; i < 4; i++) fifoQ.push_back(8'h10 + 8'(i));
        reads   = 0;
        holdBad = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (sRead) reads++;
            if (sValid && sData !== 8'h10) holdBad++;
        end
        checkOutput("stall_pops", 32'(reads), 2);
        checkOutput("stall_hold", 32'(holdBad), 0);
        checkOutput("stall_valid", 32'(sValid), 1);
        checkOutput("stall_fifo_left", 32'(fifoQ.size()), 2);
        t0 = transfers;
        for (int i = 0; i < 40 && (transfers - t0) < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("stall_drain", 32'(transfers - t0), 4);

        // enable low: no pops, FSM parks in READY; raising it pops at once.
        for (int i = 0; i < 3; i++) fifoQ.push_back(8'h20 + 8'(i));
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            if (sRead) reads++;
        end
        checkOutput("disabled_pops", 32'(reads), 0);
        checkOutput("disabled_busy", 32'(sBusy), 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("enable_resume_read", 32'(sRead), 1);
        t0 = transfers - 0;
        for (int i = 0; i < 30 && fifoQ.size() + poppedQ.size() != 0; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("enable_drain_left", 32'(fifoQ.size() + poppedQ.size()), 0);

        // fifo emptied externally while READY: no pop, back to IDLE.
        fifoQ.push_back(8'h55);
        fifoQ.push_back(8'h66);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        fifoQ.delete();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("empty_in_ready_read", 32'(sRead), 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("empty_in_ready_busy", 32'(sBusy), 0);

        // Reset with a full skid buffer: contents lost, restart from IDLE.
        for (int i = 0; i < 4; i++) fifoQ.push_back(8'h40 + 8'(i));
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("prereset_fifo_left", 32'(fifoQ.size()), 2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("postreset_valid", 32'(sValid), 0);
        checkOutput("postreset_busy", 32'(sBusy), 0);
        checkOutput("postreset_read", 32'(sRead), 0);
        firstRead = -1;
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (sRead && firstRead < 0) firstRead = i;
        end
        checkOutput("postreset_read_lat", 32'(firstRead), 2);
        t0 = transfers;
        for (int i = 0; i < 30 && (transfers - t0) < 2; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("postreset_drain", 32'(transfers - t0), 2);

`ifdef FIFO_READER_COUNT_EN
        // 300 transfers through an 8-bit counter wrap to 44.
        count_clear = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        count_clear = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("count_cleared", 32'(word_count), 0);
        for (int i = 0; i < 300; i++) fifoQ.push_back(8'(i));
        t0 = transfers;
        for (int i = 0; i < 1500 && (transfers - t0) < 300; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("count_300", 32'(transfers - t0), 300);
        checkOutput("count_wrap", 32'(word_count), 44);
        // Clear in the same cycle as a transfer: clear wins.
        fifoQ.push_back(8'h77);
        for (int i = 0; i < 10 && !sRead; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        count_clear = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        count_clear = 1'b0;
        checkOutput("clear_xfer_valid", 32'(sValid), 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clear_over_incr", 32'(word_count), 0);
`endif

        checkOutput("no_consec_reads", 32'(consecReads), 0);
        checkOutput("no_read_when_empty", 32'(badEmptyReads), 0);
        checkOutput("no_orphan_transfer", 32'(orphanXfers), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
